// File: rtl/imem_ctrl_pkg.sv
// Shared constants for the instruction-memory controller.
// Holds the AHB-Lite encodings used by the fetch master, the HPROT value
// for opcode fetches, and the default ITCM placement.
package imem_ctrl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  // Opcode fetch, privileged, non-bufferable, non-cacheable
  localparam logic [3:0] HPROT_FETCH   = 4'b0010;

  localparam logic [31:0] ITCM_BASE_DEFAULT      = 32'h0000_0000;
  localparam int          ITCM_SIZE_LOG2_DEFAULT = 16;

  // HTRANS is NONSEQ only while the address phase is being presented
  function automatic logic [1:0] htrans_for(input logic addr_phase);
    return addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
  endfunction

endpackage

// File: rtl/imem_ahb_master.sv
// Single-transfer AHB-Lite read master for instruction fetch.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i, addr_i   launch a word read of addr_i (aligned by the caller)
//   done_o            data phase completes this cycle (HREADY high)
//   err_o             completion carries an ERROR response
//   rdata_o           read data, forced to zero on error
//   haddr_o..hwrite_o AHB-Lite address/control outputs
//   hrdata_i, hready_i, hresp_i  AHB-Lite response inputs
module imem_ahb_master
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o,
  output logic [31:0]           haddr_o,
  output logic [1:0]            htrans_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [3:0]            hprot_o,
  output logic                  hwrite_o,
  input  logic [31:0]           hrdata_i,
  input  logic                  hready_i,
  input  logic                  hresp_i
);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_ADDR = 2'd1,
    M_DATA = 2'd2
  } mstate_e;

  mstate_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= M_IDLE;
      req_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_i) begin
        req_addr_q <= addr_i;
      end
    end
  end

  // A new start can only arrive while idle or in the completing data phase,
  // which lets the next address phase follow the data phase directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      M_IDLE:  if (start_i) state_d = M_ADDR;
      M_ADDR:  if (hready_i) state_d = M_DATA;
      M_DATA:  if (hready_i) state_d = start_i ? M_ADDR : M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  // The first ERROR cycle has HREADY low and is treated as an ordinary wait;
  // the error is reported only on the second, completing cycle.
  always_comb begin
    done_o   = (state_q == M_DATA) && hready_i;
    err_o    = done_o && hresp_i;
    rdata_o  = err_o ? 32'h0 : hrdata_i;
    htrans_o = htrans_for(state_q == M_ADDR);
    haddr_o  = 32'(req_addr_q);
    hsize_o  = HSIZE_WORD;
    hburst_o = HBURST_SINGLE;
    hprot_o  = HPROT_FETCH;
    hwrite_o = 1'b0;
  end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller in front of the fetch stage.
// Decodes next_pc into ITCM or AHB, keeps one request outstanding and
// returns one instruction (or an access fault) per request.
// Ports:
//   cpu_clk, cpu_rst        clock, asynchronous active-high reset
//   next_pc                 fetch address, sampled on accept cycles only
//   instr_read_data_valid   instruction returned this cycle
//   instr_read_data         instruction word (zero on fault)
//   addr_AHB                outstanding request targets AHB
//   instr_access_fault      AHB error, qualifies the valid
//   itcm_rd_en, itcm_addr   ITCM read strobe and word address
//   itcm_rdata              ITCM data, one cycle after the strobe
//   HADDR..HWRITE           AHB-Lite master address/control
//   HRDATA, HREADY, HRESP   AHB-Lite response
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ITCM_BASE      = ITCM_BASE_DEFAULT,
  parameter int                    ITCM_SIZE_LOG2 = ITCM_SIZE_LOG2_DEFAULT
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rst,
  input  logic [ADDR_WIDTH-1:0]     next_pc,
  output logic                      instr_read_data_valid,
  output logic [31:0]               instr_read_data,
  output logic                      addr_AHB,
  output logic                      instr_access_fault,
  output logic                      itcm_rd_en,
  output logic [ITCM_SIZE_LOG2-3:0] itcm_addr,
  input  logic [31:0]               itcm_rdata,
  output logic [31:0]               HADDR,
  output logic [1:0]                HTRANS,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic [3:0]                HPROT,
  output logic                      HWRITE,
  input  logic [31:0]               HRDATA,
  input  logic                      HREADY,
  input  logic                      HRESP
);

  // ST_AHB covers both AHB phases; the master sequences them internally.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITCM = 2'd1,
    ST_AHB  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  hit;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] pc_aligned;
  logic                  ahb_done;
  logic                  ahb_err;
  logic [31:0]           ahb_rdata;

  assign hit        = next_pc[ADDR_WIDTH-1:ITCM_SIZE_LOG2] ==
                      ITCM_BASE[ADDR_WIDTH-1:ITCM_SIZE_LOG2];
  assign pc_aligned = next_pc & ~ADDR_WIDTH'(3);
  // ITCM answers every cycle, AHB only when its data phase completes
  assign accept     = (state_q == ST_IDLE) || (state_q == ST_ITCM) ||
                      ((state_q == ST_AHB) && ahb_done);

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = hit ? ST_ITCM : ST_AHB;
    end
  end

  always_comb begin
    itcm_rd_en            = accept && hit;
    itcm_addr             = next_pc[ITCM_SIZE_LOG2-1:2];
    addr_AHB              = (state_q == ST_AHB);
    instr_read_data_valid = (state_q == ST_ITCM) || ((state_q == ST_AHB) && ahb_done);
    instr_access_fault    = (state_q == ST_AHB) && ahb_err;
    instr_read_data       = 32'h0;
    if (state_q == ST_ITCM) begin
      instr_read_data = itcm_rdata;
    end else if ((state_q == ST_AHB) && ahb_done) begin
      instr_read_data = ahb_rdata;
    end
  end

  imem_ahb_master #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ahb (
    .clk_i    (cpu_clk),
    .rst_i    (cpu_rst),
    .start_i  (accept && !hit),
    .addr_i   (pc_aligned),
    .done_o   (ahb_done),
    .err_o    (ahb_err),
    .rdata_o  (ahb_rdata),
    .haddr_o  (HADDR),
    .htrans_o (HTRANS),
    .hsize_o  (HSIZE),
    .hburst_o (HBURST),
    .hprot_o  (HPROT),
    .hwrite_o (HWRITE),
    .hrdata_i (HRDATA),
    .hready_i (HREADY),
    .hresp_i  (HRESP)
  );

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: directed cycle table, reset-mid-transfer
// sequence, then randomized traffic against a transaction-timing model.
module tb_imem_ctrl;

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TN = 2'b10;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic [31:0] next_pc = 32'h0;
  logic        instr_read_data_valid;
  logic [31:0] instr_read_data;
  logic        addr_AHB;
  logic        instr_access_fault;
  logic        itcm_rd_en;
  logic [13:0] itcm_addr;
  logic [31:0] itcm_rdata = 32'h0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP  = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 cpu_clk = ~cpu_clk;

  imem_ctrl dut (
    .cpu_clk               (cpu_clk),
    .cpu_rst               (cpu_rst),
    .next_pc               (next_pc),
    .instr_read_data_valid (instr_read_data_valid),
    .instr_read_data       (instr_read_data),
    .addr_AHB              (addr_AHB),
    .instr_access_fault    (instr_access_fault),
    .itcm_rd_en            (itcm_rd_en),
    .itcm_addr             (itcm_addr),
    .itcm_rdata            (itcm_rdata),
    .HADDR                 (HADDR),
    .HTRANS                (HTRANS),
    .HSIZE                 (HSIZE),
    .HBURST                (HBURST),
    .HPROT                 (HPROT),
    .HWRITE                (HWRITE),
    .HRDATA                (HRDATA),
    .HREADY                (HREADY),
    .HRESP                 (HRESP)
  );

  // ITCM contents: distinct word per address
  function automatic logic [31:0] iw(input logic [31:0] a);
    logic [13:0] w;
    w = a[15:2];
    return {w, 4'b1100, w ^ 14'h2AAA};
  endfunction

  function automatic logic [31:0] aw(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic is_itcm(input logic [31:0] a);
    return a[31:16] == 16'h0000;
  endfunction

  // Synchronous-read SRAM model
  always @(posedge cpu_clk) begin
    if (itcm_rd_en) itcm_rdata <= iw({16'h0, itcm_addr, 2'b00});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic        valid;
    logic [31:0] data;
    logic        fault;
    logic        rd_en;
    logic [13:0] iaddr;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        addr_ahb;
  } vec_t;

  function automatic vec_t v(
    input logic [31:0] pc, input logic hr, input logic hs, input logic [31:0] hd,
    input logic val, input logic [31:0] d, input logic f, input logic rd,
    input logic [13:0] ia, input logic [1:0] ht, input logic [31:0] ha, input logic aa);
    vec_t r;
    r.pc = pc; r.hready = hr; r.hresp = hs; r.hrdata = hd;
    r.valid = val; r.data = d; r.fault = f; r.rd_en = rd;
    r.iaddr = ia; r.htrans = ht; r.haddr = ha; r.addr_ahb = aa;
    return r;
  endfunction

  // Compare every observable output against expectations for this cycle
  task automatic chk_cycle(input string tag, input logic ev, input logic [31:0] ed,
                           input logic ef, input logic erd, input logic [13:0] eia,
                           input logic [1:0] eht, input logic [31:0] eha, input logic eaa);
    chk({tag, " valid"}, 32'(instr_read_data_valid), 32'(ev));
    if (ev) chk({tag, " data"}, instr_read_data, ed);
    chk({tag, " fault"}, 32'(instr_access_fault), 32'(ef));
    chk({tag, " itcm_rd_en"}, 32'(itcm_rd_en), 32'(erd));
    if (erd) chk({tag, " itcm_addr"}, 32'(itcm_addr), 32'(eia));
    chk({tag, " HTRANS"}, 32'(HTRANS), 32'(eht));
    if (eht == TN) begin
      chk({tag, " HADDR"}, HADDR, eha);
      chk({tag, " HCTRL"}, {20'h0, HSIZE, HBURST, HPROT, 1'b0, HWRITE},
          {20'h0, 3'b010, 3'b000, 4'b0010, 1'b0, 1'b0});
    end
    chk({tag, " addr_AHB"}, 32'(addr_AHB), 32'(eaa));
    if (ev) $display("txn %s: data=%h fault=%0b", tag, instr_read_data, instr_access_fault);
  endtask

  vec_t vecs[20];

  // Random-phase model state: at most one outstanding request
  logic        o_busy, o_ahb, o_err;
  logic [31:0] o_addr;
  int          o_aph, o_due;

  initial begin
    vecs[0]  = v(32'h0000_0000, 1, 0, 32'h0,        0, 32'h0,        0, 1, 14'h0,  TI, 32'h0,        0);
    vecs[1]  = v(32'h0000_0004, 1, 0, 32'h0,        1, iw(32'h0),    0, 1, 14'h1,  TI, 32'h0,        0);
    vecs[2]  = v(32'h0000_0008, 1, 0, 32'h0,        1, iw(32'h4),    0, 1, 14'h2,  TI, 32'h0,        0);
    vecs[3]  = v(32'h0000_000C, 1, 0, 32'h0,        1, iw(32'h8),    0, 1, 14'h3,  TI, 32'h0,        0);
    vecs[4]  = v(32'h2000_0000, 1, 0, 32'h0,        1, iw(32'hC),    0, 0, 14'h0,  TI, 32'h0,        0);
    vecs[5]  = v(32'h0000_0040, 1, 0, 32'h0,        0, 32'h0,        0, 0, 14'h0,  TN, 32'h2000_0000, 1);
    vecs[6]  = v(32'h2000_0010, 1, 0, 32'hA5A5_0001, 1, 32'hA5A5_0001, 0, 0, 14'h0, TI, 32'h0,        1);
    vecs[7]  = v(32'h0000_0000, 1, 0, 32'h0,        0, 32'h0,        0, 0, 14'h0,  TN, 32'h2000_0010, 1);
    vecs[8]  = v(32'h0000_0100, 0, 0, 32'h0,        0, 32'h0,        0, 0, 14'h0,  TI, 32'h0,        1);
    vecs[9]  = v(32'h0000_0100, 0, 0, 32'h0,        0, 32'h0,        0, 0, 14'h0,  TI, 32'h0,        1);
    vecs[10] = v(32'h0000_0100, 0, 0, 32'h0,        0, 32'h0,        0, 0, 14'h0,  TI, 32'h0,        1);
    vecs[11] = v(32'h0000_0100, 1, 0, 32'hA5A5_0002, 1, 32'hA5A5_0002, 0, 1, 14'h40, TI, 32'h0,       1);
    vecs[12] = v(32'h3000_0000, 1, 0, 32'h0,        1, iw(32'h100),  0, 0, 14'h0,  TI, 32'h0,        0);
    vecs[13] = v(32'h0000_0000, 1, 0, 32'h0,        0, 32'h0,        0, 0, 14'h0,  TN, 32'h3000_0000, 1);
    vecs[14] = v(32'h0000_0014, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,       0, 0, 14'h0,  TI, 32'h0,        1);
    vecs[15] = v(32'h0000_0014, 1, 1, 32'hDEAD_BEEF, 1, 32'h0,       1, 1, 14'h5,  TI, 32'h0,        1);
    vecs[16] = v(32'h0000_001B, 1, 0, 32'h0,        1, iw(32'h14),   0, 1, 14'h6,  TI, 32'h0,        0);
    vecs[17] = v(32'h0000_001F, 1, 0, 32'h0,        1, iw(32'h18),   0, 1, 14'h7,  TI, 32'h0,        0);
    vecs[18] = v(32'h2000_0100, 1, 0, 32'h0,        1, iw(32'h1C),   0, 0, 14'h0,  TI, 32'h0,        0);
    vecs[19] = v(32'h0000_0000, 1, 0, 32'h0,        0, 32'h0,        0, 0, 14'h0,  TN, 32'h2000_0100, 1);

    // Reset state
    repeat (2) @(posedge cpu_clk);
    #4;
    chk("rst valid", 32'(instr_read_data_valid), 32'h0);
    chk("rst fault", 32'(instr_access_fault), 32'h0);
    chk("rst addr_AHB", 32'(addr_AHB), 32'h0);
    chk("rst HTRANS", 32'(HTRANS), 32'(TI));
    chk("rst HADDR", HADDR, 32'h0);

    // Directed table
    for (int i = 0; i < 20; i++) begin
      @(posedge cpu_clk);
      #1;
      cpu_rst = 1'b0;
      next_pc = vecs[i].pc;
      HREADY  = vecs[i].hready;
      HRESP   = vecs[i].hresp;
      HRDATA  = vecs[i].hrdata;
      #3;
      chk_cycle($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data, vecs[i].fault,
                vecs[i].rd_en, vecs[i].iaddr, vecs[i].htrans, vecs[i].haddr, vecs[i].addr_ahb);
    end

    // Reset asserted during the AHB data phase of 0x2000_0100
    @(posedge cpu_clk);
    #1;
    HREADY  = 1'b0;
    next_pc = 32'h0000_0020;
    #1;
    chk("mid addr_AHB", 32'(addr_AHB), 32'h1);
    cpu_rst = 1'b1;
    #1;
    chk("arst HTRANS", 32'(HTRANS), 32'(TI));
    chk("arst addr_AHB", 32'(addr_AHB), 32'h0);
    chk("arst valid", 32'(instr_read_data_valid), 32'h0);
    chk("arst HADDR", HADDR, 32'h0);
    HREADY = 1'b1;
    HRDATA = 32'h1234_5678;
    repeat (2) begin
      @(posedge cpu_clk);
      #4;
      chk("rst hold valid", 32'(instr_read_data_valid), 32'h0);
    end
    @(posedge cpu_clk);
    #1;
    cpu_rst = 1'b0;
    #3;
    chk_cycle("refetch0", 1'b0, 32'h0, 1'b0, 1'b1, 14'h8, TI, 32'h0, 1'b0);
    @(posedge cpu_clk);
    #4;
    chk_cycle("refetch1", 1'b1, iw(32'h20), 1'b0, 1'b1, 14'h8, TI, 32'h0, 1'b0);

    // Randomized traffic against the timing model
    cpu_rst = 1'b1;
    repeat (2) @(posedge cpu_clk);
    o_busy = 1'b0; o_ahb = 1'b0; o_err = 1'b0; o_addr = 32'h0; o_aph = 0; o_due = 0;
    for (int c = 0; c < 400; c++) begin
      logic [31:0] pc, lo;
      logic        acc, ev, ehit;
      int          hi, w;
      @(posedge cpu_clk);
      #1;
      cpu_rst = 1'b0;
      lo = $urandom;
      hi = $urandom_range(1, 65535);
      pc = ($urandom_range(0, 1) == 0) ? {16'h0, lo[15:0]} : {16'(hi), lo[15:0]};
      next_pc = pc;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = $urandom;
      if (o_busy && o_ahb) begin
        if (c > o_aph && c < o_due) begin
          HREADY = 1'b0;
          HRESP  = o_err && (c == o_due - 1);
        end else if (c == o_due) begin
          HRESP  = o_err;
          HRDATA = o_err ? (32'($urandom) | 32'h1) : aw(o_addr);
        end
      end
      #3;
      ev   = o_busy && (c == o_due);
      acc  = !o_busy || ev;
      ehit = is_itcm(pc);
      chk_cycle($sformatf("rnd%0d", c), ev,
                (o_ahb ? (o_err ? 32'h0 : aw(o_addr)) : iw(o_addr)),
                ev && o_ahb && o_err, acc && ehit, pc[15:2],
                (o_busy && o_ahb && c == o_aph) ? TN : TI, o_addr,
                o_busy && o_ahb);
      if (ev) o_busy = 1'b0;
      if (acc) begin
        o_busy = 1'b1;
        o_addr = {pc[31:2], 2'b00};
        o_ahb  = !ehit;
        o_err  = 1'b0;
        if (o_ahb) begin
          w     = $urandom_range(0, 3);
          o_err = ($urandom_range(0, 4) == 0);
          o_aph = c + 1;
          o_due = c + 2 + w + (o_err ? 1 : 0);
        end else begin
          o_due = c + 1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
